// File: rtl/dec_enc_codec.sv
// Registered binary-to-one-hot decoder feeding a highest-priority one-hot/multi-hot encoder.
// loop_sel routes the decoder register into the encoder, giving a din -> enc_out self-test path.
module dec_enc_codec #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEL_W-1:0]      din,
  input  logic [(1<<SEL_W)-1:0] enc_in,
  input  logic                  loop_sel,
  output logic [(1<<SEL_W)-1:0] dec_out,
  output logic [SEL_W-1:0]      enc_out,
  output logic                  enc_valid,
  output logic                  enc_multi
);

  localparam int N = 1 << SEL_W;

  // Highest set bit wins; an all-zero vector maps to index 0.
  function automatic logic [SEL_W-1:0] prio_idx(input logic [N-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if more than one bit was set.
  function automatic logic is_multi(input logic [N-1:0] v);
    return |(v & (v - N'(1)));
  endfunction

  logic [N-1:0]     dec_nxt_p0;
  logic [N-1:0]     enc_src_p0;
  logic [SEL_W-1:0] enc_nxt_p0;
  logic             vld_nxt_p0;
  logic             multi_nxt_p0;

  always_comb begin
    dec_nxt_p0   = en ? (N'(1) << din) : '0;
    enc_src_p0   = loop_sel ? dec_out : enc_in;
    enc_nxt_p0   = en ? prio_idx(enc_src_p0) : '0;
    vld_nxt_p0   = en & (|enc_src_p0);
    multi_nxt_p0 = en & is_multi(enc_src_p0);
  end

  // p0 -> p1: all outputs registered; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out   <= '0;
      enc_out   <= '0;
      enc_valid <= 1'b0;
      enc_multi <= 1'b0;
    end else begin
      dec_out   <= dec_nxt_p0;
      enc_out   <= enc_nxt_p0;
      enc_valid <= vld_nxt_p0;
      enc_multi <= multi_nxt_p0;
    end
  end

endmodule

// File: tb/tb_dec_enc_codec.sv
// Directed bench for dec_enc_codec: table of per-cycle vectors plus hand sequences for async reset.
module tb_dec_enc_codec;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] din;
  logic [7:0] enc_in;
  logic       loop_sel;
  logic [7:0] dec_out;
  logic [2:0] enc_out;
  logic       enc_valid;
  logic       enc_multi;

  int n_cmp = 0;
  int n_bad = 0;

  dec_enc_codec #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .enc_in(enc_in),
    .loop_sel(loop_sel), .dec_out(dec_out), .enc_out(enc_out),
    .enc_valid(enc_valid), .enc_multi(enc_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       loop_sel;
    logic [2:0] din;
    logic [7:0] enc_in;
    logic [7:0] exp_dec;
    logic [2:0] exp_enc;
    logic       exp_v;
    logic       exp_m;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic ls, input logic [2:0] d, input logic [7:0] ei,
                     input logic [7:0] xd, input logic [2:0] xe, input logic xv, input logic xm);
    vec_t v;
    v.en = e; v.loop_sel = ls; v.din = d; v.enc_in = ei;
    v.exp_dec = xd; v.exp_enc = xe; v.exp_v = xv; v.exp_m = xm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] xd, input logic [2:0] xe,
                           input logic xv, input logic xm);
    check({tag, ".dec_out"},   32'(dec_out),   32'(xd));
    check({tag, ".enc_out"},   32'(enc_out),   32'(xe));
    check({tag, ".enc_valid"}, 32'(enc_valid), 32'(xv));
    check({tag, ".enc_multi"}, 32'(enc_multi), 32'(xm));
  endtask

  // Drive inputs just after a rising edge, then check just after the next one.
  task automatic step(input logic e, input logic ls, input logic [2:0] d, input logic [7:0] ei);
    en = e; loop_sel = ls; din = d; enc_in = ei;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b1; din = 3'd5; enc_in = 8'h00; loop_sel = 1'b0;

    // Reset must act before any clock edge
    #1 rst_n = 1'b0;
    #1 check_all("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Decode sweep
    add(1, 0, 3'd0, 8'h00, 8'h01, 3'd0, 0, 0);
    add(1, 0, 3'd1, 8'h00, 8'h02, 3'd0, 0, 0);
    add(1, 0, 3'd2, 8'h00, 8'h04, 3'd0, 0, 0);
    add(1, 0, 3'd3, 8'h00, 8'h08, 3'd0, 0, 0);
    add(1, 0, 3'd4, 8'h00, 8'h10, 3'd0, 0, 0);
    add(1, 0, 3'd5, 8'h00, 8'h20, 3'd0, 0, 0);
    add(1, 0, 3'd6, 8'h00, 8'h40, 3'd0, 0, 0);
    add(1, 0, 3'd7, 8'h00, 8'h80, 3'd0, 0, 0);
    // Disable clears everything, even with a live encoder input
    add(0, 0, 3'd3, 8'hFF, 8'h00, 3'd0, 0, 0);
    // Priority encoder on external input
    add(1, 0, 3'd0, 8'b0010_0110, 8'h01, 3'd5, 1, 1);
    add(1, 0, 3'd0, 8'h00,        8'h01, 3'd0, 0, 0);
    add(1, 0, 3'd0, 8'h80,        8'h01, 3'd7, 1, 0);
    add(1, 0, 3'd0, 8'h01,        8'h01, 3'd0, 1, 0);
    add(1, 0, 3'd0, 8'hFF,        8'h01, 3'd7, 1, 1);
    add(1, 0, 3'd0, 8'b0001_1000, 8'h01, 3'd4, 1, 1);
    // Loopback: encoder sees the previous decode (dec_out=01 entering this block)
    add(1, 1, 3'd0, 8'hFF, 8'h01, 3'd0, 1, 0);
    add(1, 1, 3'd1, 8'hFF, 8'h02, 3'd0, 1, 0);
    add(1, 1, 3'd2, 8'hFF, 8'h04, 3'd1, 1, 0);
    add(1, 1, 3'd3, 8'hFF, 8'h08, 3'd2, 1, 0);
    add(1, 1, 3'd4, 8'hFF, 8'h10, 3'd3, 1, 0);
    add(1, 1, 3'd5, 8'hFF, 8'h20, 3'd4, 1, 0);
    add(1, 1, 3'd6, 8'hFF, 8'h40, 3'd5, 1, 0);
    add(1, 1, 3'd7, 8'hFF, 8'h80, 3'd6, 1, 0);
    add(1, 1, 3'd0, 8'hFF, 8'h01, 3'd7, 1, 0);
    add(1, 1, 3'd1, 8'hFF, 8'h02, 3'd0, 1, 0);
    // en drop in loopback, then rise: first encode sees an empty dec_out
    add(0, 1, 3'd5, 8'hFF, 8'h00, 3'd0, 0, 0);
    add(1, 1, 3'd3, 8'hFF, 8'h08, 3'd0, 0, 0);
    add(1, 1, 3'd4, 8'hFF, 8'h10, 3'd3, 1, 0);
    add(1, 1, 3'd6, 8'hFF, 8'h40, 3'd4, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].loop_sel, vecs[i].din, vecs[i].enc_in);
      check_all($sformatf("vec%0d", i), vecs[i].exp_dec, vecs[i].exp_enc,
                vecs[i].exp_v, vecs[i].exp_m);
    end

    // Async reset mid-cycle with din=6 decoded and din=7 in flight
    en = 1'b1; loop_sel = 1'b1; din = 3'd7;
    #2 rst_n = 1'b0;
    #1 check_all("reset_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_mid_edge", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Round trip restarts with two-cycle latency
    step(1, 1, 3'd2, 8'h00);
    check_all("restart1", 8'h04, 3'd0, 1'b0, 1'b0);
    step(1, 1, 3'd3, 8'h00);
    check_all("restart2", 8'h08, 3'd2, 1'b1, 1'b0);
    step(1, 1, 3'd3, 8'h00);
    check_all("restart3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Switch loopback off mid-stream: encoder follows enc_in at once
    step(1, 0, 3'd1, 8'b0100_0001);
    check_all("loop_off", 8'h02, 3'd6, 1'b1, 1'b1);
    step(0, 1, 3'd1, 8'h00);
    check_all("final_dis", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
